fifo_stream_reader: RTL

Read-side adapter for the synchronous FIFO. It drives the FIFO's `rd_en`, absorbs the one-cycle registered read latency, and presents the words on a valid/ready stream in first-word-fall-through order. It sits between a FIFO and a downstream consumer such as a DAC serializer or delay tap, and sustains one word per clock.

---
 rtl/fifo_stream_reader.sv | 86 ++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side adapter: drives FIFO rd_en, absorbs the one-cycle read latency and
// presents words first-word-fall-through on valid/ready. FIFO_READER_COUNT_EN adds xfer_count.
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_data,
    input  logic                 flush,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready
`ifdef FIFO_READER_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] xfer_count
`endif
);

    if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
        $error("fifo_stream_reader: WIDTH and CNT_WIDTH must be positive");
    end

    logic [1:0]            count;
    logic                  pending;
    logic [1:0][WIDTH-1:0] slot;
    logic [1:0][WIDTH-1:0] slot_next;
    logic                  pop;
    logic [2:0]            occ;
    logic [1:0]            keep;

    assign m_valid = (count != 2'd0);
    assign m_data  = slot[0];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        slot_next  = slot;
        pop        = m_valid && m_ready;
        keep       = count - {1'b0, pop};
        occ        = {1'b0, count} + {2'b0, pending} - {2'b0, pop};
        fifo_rd_en = n_reset && !flush && !fifo_empty && (occ <= 3'd1);

        if (pop) begin
            slot_next[0] = slot[1];
        end
        // The arriving word lands behind whatever survives this cycle's pop.
        if (pending) begin
            if (keep == 2'd0) begin
                slot_next[0] = fifo_data;
            end else begin
                slot_next[1] = fifo_data;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the two-word buffer is reset on purpose so m_data reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            count   <= 2'd0;
            pending <= 1'b0;
            slot    <= '0;
        end else if (flush) begin
            count   <= 2'd0;
            pending <= 1'b0;
        end else begin
            count   <= occ[1:0];
            pending <= fifo_rd_en;
            slot    <= slot_next;
        end
    end

`ifdef FIFO_READER_COUNT_EN
    // A pop in the flush cycle is a completed handshake but the clear wins.
    always_ff @(posedge clk) begin
        if (!n_reset || flush) begin
            xfer_count <= '0;
        end else if (pop) begin
            xfer_count <= xfer_count + 1'b1;
        end
    end
`endif

endmodule
